param_counter: RTL and testbench

Parametrised load-and-count block, the next generation of the lab's single-target up-counter. It captures a target value on `in_valid` and then steps `out_num` toward a terminal value, one step per cycle, in up, down or free-running repeat mode. It supports hold/freeze and a one-cycle `done` strobe. Programmable step size is available as a compile-time option. It is a drop-in counter/timer for lab datapaths; mode 00 with step 1 reproduces the legacy up-counter sequence.

---
 rtl/param_counter.sv | 133 +++++++++++++
 tb/tb_param_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/param_counter.sv
// Parametrised load-and-count block: up, down and repeat-up modes with hold and a done strobe.
// Optional PARAM_COUNTER_STEP_EN adds the in_step port and a programmable step size.
module param_counter #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_num,
  input  logic [1:0]       in_mode,
`ifdef PARAM_COUNTER_STEP_EN
  input  logic [WIDTH-1:0] in_step,
`endif
  input  logic             hold,
  output logic [WIDTH-1:0] out_num,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_RPT  = 2'b10;

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_w;
  logic [1:0]       mode_in_c;
  logic [CW-1:0]    sum_c;
  logic [WIDTH-1:0] up_next_c;
  logic [WIDTH-1:0] dn_next_c;

`ifdef PARAM_COUNTER_STEP_EN
  logic [WIDTH-1:0] step_q, step_d;
  assign step_w = step_q;
`else
  assign step_w = WIDTH'(1);
`endif

  // Reserved mode 11 folds onto plain up-count at capture time.
  assign mode_in_c = (in_mode == 2'b11) ? MODE_UP : in_mode;

  // Saturating up step in WIDTH+1 bits so the sum never wraps.
  assign sum_c     = CW'(count_q) + CW'(step_w);
  assign up_next_c = (sum_c > CW'(target_q)) ? target_q : WIDTH'(sum_c);
  assign dn_next_c = (count_q >= step_w) ? (count_q - step_w) : '0;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    count_d  = count_q;
    done_d   = 1'b0;
`ifdef PARAM_COUNTER_STEP_EN
    step_d   = step_q;
`endif
    if (in_valid) begin
      target_d = in_num;
      mode_d   = mode_in_c;
`ifdef PARAM_COUNTER_STEP_EN
      step_d   = (in_step == '0) ? WIDTH'(1) : in_step;
`endif
      count_d  = (mode_in_c == MODE_DOWN) ? in_num : '0;
      if (in_num == '0) begin
        done_d  = 1'b1;
        state_d = (mode_in_c == MODE_RPT) ? RUN : IDLE;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && !hold) begin
      case (mode_q)
        MODE_DOWN: begin
          count_d = dn_next_c;
          if (dn_next_c == '0) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        MODE_RPT: begin
          if (count_q == target_q) begin
            count_d = '0;
          end else begin
            count_d = up_next_c;
            done_d  = (up_next_c == target_q);
          end
        end
        default: begin
          count_d = up_next_c;
          if (up_next_c == target_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      endcase
    end
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      mode_q   <= MODE_UP;
      count_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PARAM_COUNTER_STEP_EN
      step_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PARAM_COUNTER_STEP_EN
      step_q   <= step_d;
`endif
    end
  end

  assign out_num = count_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed self-checking bench for param_counter (WIDTH=5); step-size cases run only when
// PARAM_COUNTER_STEP_EN is defined.
module tb_param_counter;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_num;
  logic [1:0] in_mode;
`ifdef PARAM_COUNTER_STEP_EN
  logic [4:0] in_step;
`endif
  logic       hold;
  logic [4:0] out_num;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  param_counter #(.WIDTH(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_num   (in_num),
    .in_mode  (in_mode),
`ifdef PARAM_COUNTER_STEP_EN
    .in_step  (in_step),
`endif
    .hold     (hold),
    .out_num  (out_num),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] e_out, input logic e_busy,
                     input logic e_done);
    checks++;
    assert (out_num === e_out) else begin
      errors++;
      $error("FAIL %s out_num: got %0d expected %0d", tag, out_num, e_out);
    end
    checks++;
    assert (busy === e_busy) else begin
      errors++;
      $error("FAIL %s busy: got %0b expected %0b", tag, busy, e_busy);
    end
    checks++;
    assert (done === e_done) else begin
      errors++;
      $error("FAIL %s done: got %0b expected %0b", tag, done, e_done);
    end
  endtask

  task automatic load(input logic [4:0] n, input logic [1:0] m);
    in_valid = 1'b1;
    in_num   = n;
    in_mode  = m;
    tick();
    in_valid = 1'b0;
  endtask

`ifdef PARAM_COUNTER_STEP_EN
  task automatic load_step(input logic [4:0] n, input logic [1:0] m, input logic [4:0] s);
    in_step = s;
    load(n, m);
  endtask
`endif

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_num   = '0;
    in_mode  = '0;
    hold     = 1'b0;
`ifdef PARAM_COUNTER_STEP_EN
    in_step  = 5'd1;
`endif
    #12;
    chk("reset", 5'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 5'd0, 1'b0, 1'b0);

    // Up to 5
    load(5'd5, 2'b00);
    chk("up5_start", 5'd0, 1'b1, 1'b0);
    for (int v = 1; v <= 4; v++) begin
      tick();
      chk("up5_walk", 5'(v), 1'b1, 1'b0);
    end
    tick();
    chk("up5_done", 5'd5, 1'b0, 1'b1);
    tick();
    chk("up5_holdval", 5'd5, 1'b0, 1'b0);

    // Down from 3, then target 0 in up mode
    load(5'd3, 2'b01);
    chk("dn3_start", 5'd3, 1'b1, 1'b0);
    tick(); chk("dn3_2", 5'd2, 1'b1, 1'b0);
    tick(); chk("dn3_1", 5'd1, 1'b1, 1'b0);
    tick(); chk("dn3_done", 5'd0, 1'b0, 1'b1);
    load(5'd0, 2'b00);
    chk("up0_done", 5'd0, 1'b0, 1'b1);
    tick(); chk("up0_idle", 5'd0, 1'b0, 1'b0);

    // Repeat to 2, then switch to up 1
    load(5'd2, 2'b10);
    chk("rpt_0a", 5'd0, 1'b1, 1'b0);
    tick(); chk("rpt_1a", 5'd1, 1'b1, 1'b0);
    tick(); chk("rpt_2a", 5'd2, 1'b1, 1'b1);
    tick(); chk("rpt_0b", 5'd0, 1'b1, 1'b0);
    tick(); chk("rpt_1b", 5'd1, 1'b1, 1'b0);
    tick(); chk("rpt_2b", 5'd2, 1'b1, 1'b1);
    load(5'd1, 2'b00);
    chk("up1_start", 5'd0, 1'b1, 1'b0);
    tick(); chk("up1_done", 5'd1, 1'b0, 1'b1);
    tick(); chk("up1_idle", 5'd1, 1'b0, 1'b0);

    // Up to 6 with a 3-cycle hold at 2
    load(5'd6, 2'b00);
    chk("up6_0", 5'd0, 1'b1, 1'b0);
    tick(); chk("up6_1", 5'd1, 1'b1, 1'b0);
    tick(); chk("up6_2", 5'd2, 1'b1, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("up6_hold", 5'd2, 1'b1, 1'b0);
    end
    hold = 1'b0;
    tick(); chk("up6_3", 5'd3, 1'b1, 1'b0);
    tick(); chk("up6_4", 5'd4, 1'b1, 1'b0);
    tick(); chk("up6_5", 5'd5, 1'b1, 1'b0);
    tick(); chk("up6_done", 5'd6, 1'b0, 1'b1);

    // Load under hold mid-count restarts
    load(5'd6, 2'b00);
    tick(); tick();
    chk("reload_pre", 5'd2, 1'b1, 1'b0);
    hold = 1'b1;
    load(5'd4, 2'b00);
    chk("reload_start", 5'd0, 1'b1, 1'b0);
    tick(); chk("reload_frozen", 5'd0, 1'b1, 1'b0);
    hold = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      tick();
      chk("reload_walk", 5'(v), 1'b1, 1'b0);
    end
    tick(); chk("reload_done", 5'd4, 1'b0, 1'b1);

    // Reserved mode behaves as up
    load(5'd2, 2'b11);
    chk("m11_0", 5'd0, 1'b1, 1'b0);
    tick(); chk("m11_1", 5'd1, 1'b1, 1'b0);
    tick(); chk("m11_done", 5'd2, 1'b0, 1'b1);

    // Async reset mid-count
    load(5'd5, 2'b00);
    tick(); tick(); tick();
    chk("rst_pre", 5'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("rst_immediate", 5'd0, 1'b0, 1'b0);
    #3 rst_n = 1'b1;
    tick(); chk("rst_idle_1", 5'd0, 1'b0, 1'b0);
    tick(); chk("rst_idle_2", 5'd0, 1'b0, 1'b0);

`ifdef PARAM_COUNTER_STEP_EN
    load_step(5'd10, 2'b00, 5'd4);
    chk("s4up_0", 5'd0, 1'b1, 1'b0);
    tick(); chk("s4up_4", 5'd4, 1'b1, 1'b0);
    tick(); chk("s4up_8", 5'd8, 1'b1, 1'b0);
    tick(); chk("s4up_10", 5'd10, 1'b0, 1'b1);
    load_step(5'd10, 2'b01, 5'd4);
    chk("s4dn_10", 5'd10, 1'b1, 1'b0);
    tick(); chk("s4dn_6", 5'd6, 1'b1, 1'b0);
    tick(); chk("s4dn_2", 5'd2, 1'b1, 1'b0);
    tick(); chk("s4dn_0", 5'd0, 1'b0, 1'b1);
    load_step(5'd2, 2'b00, 5'd0);
    chk("s0_0", 5'd0, 1'b1, 1'b0);
    tick(); chk("s0_1", 5'd1, 1'b1, 1'b0);
    tick(); chk("s0_done", 5'd2, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
